disp_hole_fill: RTL and testbench
=================================

DISP_HOLE_FILL -- requirements
Module: disp_hole_fill

Interface
REQ-001 SHALL have parameter frame_w, default 80, pixels per row of the decimated disparity frame.
REQ-002 SHALL have parameter frame_h, default 160, rows per frame.
REQ-003 SHALL have parameter disp_bits, default 5, disparity width in bits.
REQ-004 SHALL have parameter conf_thresh, default 8'd32, minimum confidence for a pixel to count as valid.
REQ-005 SHALL have parameter max_fill, default 16, longest hole run that is filled.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-008 SHALL have port in_data, input, 16 bits: disparity in [8+disp_bits-1:8] and confidence in [7:0], with the remaining upper bits ignored.
REQ-009 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit), the upstream handshake.
REQ-010 SHALL have port out_data, output, 8 bits, filled disparity zero-extended.
REQ-011 SHALL have port out_filled, output, 1 bit, set when out_data is a substituted value.
REQ-012 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit), the downstream handshake.
REQ-013 SHALL have port frame_done, output, 1 bit, one-cycle pulse.

Function
REQ-014 SHALL accept an input beat when in_valid && in_ready; in_ready = !out_valid || out_ready, combinational.
REQ-015 SHALL register each output in a single stage: latency is 1 cycle from acceptance to out_valid.
REQ-016 SHALL hold out_data, out_filled and out_valid stable while out_valid && !out_ready.
REQ-017 SHALL clear out_valid on a cycle where out_ready is high and no beat is accepted.
REQ-018 SHALL treat a pixel as valid when its confidence is >= conf_thresh (unsigned compare).
REQ-019 For a valid pixel, the block SHALL output its disparity with out_filled=0, load last_disp with that disparity and clear run_cnt to 0.
REQ-020 For an invalid pixel with run_cnt < max_fill, the block SHALL output last_disp with out_filled=1 and increment run_cnt.
REQ-021 For an invalid pixel with run_cnt >= max_fill, the block SHALL output 0 with out_filled=1; run_cnt saturates at max_fill.
REQ-022 SHALL treat column 0 of every row as having last_disp=0 and run_cnt=0 before the REQ-019..021 decision, so there is no fill across row boundaries.
REQ-023 SHALL keep col_cnt (0..frame_w-1) and row_cnt (0..frame_h-1), both advancing only on accepted beats.
REQ-024 SHALL wrap col_cnt to 0 after frame_w-1, incrementing row_cnt at that point.
REQ-025 SHALL wrap row_cnt to 0 after frame_h-1.
REQ-026 SHALL pulse frame_done high for exactly one cycle, in the cycle after the beat at col frame_w-1 / row frame_h-1 is accepted.
REQ-027 SHALL start the next frame at col 0 / row 0 immediately; back-to-back frames need no idle gap.
REQ-028 SHALL produce a deterministic output for in_valid deasserted mid-row: counters and last_disp hold, and results are identical to an unstalled stream.

Reset
REQ-029 On reset assertion, regardless of the clock, the block SHALL force out_valid=0, out_data=0, out_filled=0, frame_done=0, col_cnt=0, row_cnt=0, last_disp=0 and run_cnt=0.
REQ-030 After reset deassertion, the first accepted beat SHALL be treated as col 0 / row 0.
REQ-031 A reset mid-frame SHALL discard the partial frame and SHALL NOT produce a frame_done pulse for it.

Verification
REQ-032 Full row of confidence 255, disparity = col mod 32, out_ready=1 -> outputs equal inputs, out_filled=0, one beat per cycle, latency 1.
REQ-033 Row of disparities 7, 7, then 3 pixels with confidence 10, then disparity 9 -> outputs 7,7,7,7,7,9 with out_filled=0,0,1,1,1,0.
REQ-034 Invalid run of 20 after disparity 12, max_fill=16 -> 16 outputs of 12 then 4 outputs of 0, all with out_filled=1.
REQ-035 Last pixel of a row has disparity 20 and the next row starts with 2 invalid pixels -> next-row outputs 0,0 with out_filled=1.
REQ-036 Full 80x160 frame with random in_valid and 50% out_ready -> 12800 outputs matching the golden model file, and exactly one frame_done after the last accept.
REQ-037 Reset asserted at row 40, then a fresh frame -> out_valid drops immediately, no frame_done, and the new frame matches golden from pixel 0.

Source files
------------

// File: rtl/disp_hole_fill.sv
// Disparity hole filler for a decimated stereo stream.
// Low-confidence pixels are replaced by the last confident disparity
// of the same row, for at most max_fill pixels per run. Past that
// limit, and at the start of every row, they are replaced by zero.
// The block has a single registered output stage with a
// valid/ready handshake on each side.
module disp_hole_fill #(
   parameter int         frame_w     = 80,
   parameter int         frame_h     = 160,
   parameter int         disp_bits   = 5,
   parameter logic [7:0] conf_thresh = 8'd32,
   parameter int         max_fill    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_data,
   output logic        out_filled,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        frame_done
);

   localparam int col_bits = (frame_w > 1) ? $clog2(frame_w) : 1;
   localparam int row_bits = (frame_h > 1) ? $clog2(frame_h) : 1;
   localparam int run_bits = $clog2(max_fill + 1);

   logic [col_bits-1:0]  col_cnt;
   logic [row_bits-1:0]  row_cnt;
   logic [disp_bits-1:0] last_disp;
   logic [run_bits-1:0]  run_cnt;

   logic                 accept;
   logic                 last_col;
   logic                 last_row;
   logic                 pix_ok;
   logic [disp_bits-1:0] pix_disp;
   logic [7:0]           pix_conf;
   logic [disp_bits-1:0] eff_last;
   logic [run_bits-1:0]  eff_run;

   logic [7:0]           nxt_data;
   logic                 nxt_filled;
   logic [disp_bits-1:0] nxt_last;
   logic [run_bits-1:0]  nxt_run;

   // The bits above the disparity field carry no meaning for this block.
   logic unused_upper;
   assign unused_upper = ^(in_data >> (8 + disp_bits));

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   assign pix_disp = in_data[8 +: disp_bits];
   assign pix_conf = in_data[7:0];
   assign pix_ok   = (pix_conf >= conf_thresh);

   assign last_col = (col_cnt == col_bits'(frame_w - 1));
   assign last_row = (row_cnt == row_bits'(frame_h - 1));

   // At column 0 the fill history is forced to empty, so values never carry across rows.
   assign eff_last = (col_cnt == '0) ? '0 : last_disp;
   assign eff_run  = (col_cnt == '0) ? '0 : run_cnt;

   // Decide the output value and the updated fill history for the incoming pixel.
   always_comb begin
      nxt_data   = '0;
      nxt_filled = 1'b0;
      nxt_last   = eff_last;
      nxt_run    = eff_run;
      if (pix_ok) begin
         nxt_data   = 8'(pix_disp);
         nxt_filled = 1'b0;
         nxt_last   = pix_disp;
         nxt_run    = '0;
      end else if (eff_run < run_bits'(max_fill)) begin
         nxt_data   = 8'(eff_last);
         nxt_filled = 1'b1;
         nxt_run    = eff_run + 1'b1;
      end else begin
         nxt_data   = '0;
         nxt_filled = 1'b1;
         nxt_run    = run_bits'(max_fill);
      end
   end

   // Output register: load on accept, otherwise hold while stalled or empty once drained.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_filled <= 1'b0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         out_data   <= nxt_data;
         out_filled <= nxt_filled;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

   // Fill history only changes on accepted beats, so input stalls have no effect on results.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_disp <= '0;
         run_cnt   <= '0;
      end else if (accept) begin
         last_disp <= nxt_last;
         run_cnt   <= nxt_run;
      end
   end

   // Raster position tracking and a single-cycle end-of-frame pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_cnt    <= '0;
         row_cnt    <= '0;
         frame_done <= 1'b0;
      end else if (accept) begin
         frame_done <= last_col && last_row;
         if (last_col) begin
            col_cnt <= '0;
            row_cnt <= last_row ? '0 : row_cnt + 1'b1;
         end else begin
            col_cnt <= col_cnt + 1'b1;
         end
      end else begin
         frame_done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_disp_hole_fill.sv
// Self-checking bench for disp_hole_fill: directed vector table,
// hand-written row sequences, and randomized frames against a
// row-history reference model.
module tb_disp_hole_fill;

   localparam int FW       = 80;
   localparam int FH       = 160;
   localparam int MAX_FILL = 16;
   localparam int THRESH   = 32;

   logic        clk;
   logic        reset;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_filled;
   logic        out_valid;
   logic        out_ready;
   logic        frame_done;

   int tests_run    = 0;
   int tests_failed = 0;
   int ready_pct    = 100;
   int fd_count     = 0;
   int pop_count    = 0;

   disp_hole_fill #(
      .frame_w(FW), .frame_h(FH), .disp_bits(5),
      .conf_thresh(8'd32), .max_fill(MAX_FILL)
   ) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_filled(out_filled),
      .out_valid(out_valid), .out_ready(out_ready),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream ready pattern, refreshed just after every rising edge.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = ($urandom_range(99) < ready_pct);
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests_run++;
      if (actual != expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   typedef struct {
      int data;
      int filled;
   } exp_t;

   exp_t exp_q[$];
   int   m_disp[FW];
   bit   m_ok[FW];
   int   m_col, m_row;
   bit   fd_pend;
   bit   hold_v;
   int   hold_d, hold_f;

   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         m_col   = 0;
         m_row   = 0;
         fd_pend = 0;
         hold_v  = 0;
      end else begin
         checkOutput("frame_done", int'(frame_done), int'(fd_pend));
         fd_pend = 0;
         if (frame_done) fd_count++;
         if (hold_v) begin
            checkOutput("hold_valid", int'(out_valid), 1);
            checkOutput("hold_data", int'(out_data), hold_d);
            checkOutput("hold_filled", int'(out_filled), hold_f);
         end
         hold_v = out_valid && !out_ready;
         hold_d = int'(out_data);
         hold_f = int'(out_filled);
         if (out_valid && out_ready) begin
            pop_count++;
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_output", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               checkOutput("sb_data", int'(out_data), e.data);
               checkOutput("sb_filled", int'(out_filled), e.filled);
            end
         end
         if (in_valid && in_ready) begin
            exp_t e;
            int d, c, idx;
            d   = int'(in_data[12:8]);
            c   = int'(in_data[7:0]);
            idx = -1;
            if (c >= THRESH) begin
               e.data   = d;
               e.filled = 0;
            end else begin
               // Find the nearest confident pixel earlier in this row.
               for (int j = m_col - 1; j >= 0; j--) begin
                  if (m_ok[j]) begin
                     idx = j;
                     break;
                  end
               end
               e.filled = 1;
               e.data   = (idx >= 0 && (m_col - idx) <= MAX_FILL) ? m_disp[idx] : 0;
            end
            exp_q.push_back(e);
            m_ok[m_col]   = (c >= THRESH);
            m_disp[m_col] = d;
            if (m_col == FW - 1 && m_row == FH - 1) fd_pend = 1;
            if (m_col == FW - 1) begin
               m_col = 0;
               m_row = (m_row == FH - 1) ? 0 : m_row + 1;
            end else begin
               m_col++;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic resetDut();
      @(posedge clk);
      #3;
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst_out_data", int'(out_data), 0);
      checkOutput("rst_out_filled", int'(out_filled), 0);
      checkOutput("rst_frame_done", int'(frame_done), 0);
      @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   // Drive one beat with ready held high, then sample the registered result.
   task automatic applyStimulus(input int d, input int c);
      in_data  = {3'b000, 5'(d), 8'(c)};
      in_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic checkBeat(input string name, input int d, input int f);
      checkOutput({name, "_valid"}, int'(out_valid), 1);
      checkOutput({name, "_data"}, int'(out_data), d);
      checkOutput({name, "_filled"}, int'(out_filled), f);
   endtask

   task automatic driveRandom(input int n, input int idle_pct);
      int row, waited;
      logic [7:0] c;
      logic [4:0] d;
      for (int i = 0; i < n; i++) begin
         row = (i / FW) % FH;
         while ($urandom_range(99) < idle_pct) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         d = 5'($urandom);
         if (row % 4 == 0)
            c = ($urandom_range(19) == 0) ? 8'd200 : 8'($urandom_range(0, 31));
         else
            c = 8'($urandom_range(0, 255));
         in_data  = {3'($urandom), d, c};
         in_valid = 1'b1;
         waited   = 0;
         @(negedge clk);
         while (!in_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
         end
         if (!in_ready) begin
            checkOutput("in_ready_timeout", 0, 1);
            break;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      ready_pct = 100;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("queue_empty", exp_q.size(), 0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int disp;
      int conf;
      int exp_data;
      int exp_filled;
   } vec_t;

   vec_t vecs[29];

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;

      vecs[0] = '{7, 255, 7, 0};
      vecs[1] = '{7, 255, 7, 0};
      vecs[2] = '{5, 10, 7, 1};
      vecs[3] = '{5, 10, 7, 1};
      vecs[4] = '{5, 10, 7, 1};
      vecs[5] = '{9, 255, 9, 0};
      vecs[6] = '{12, 255, 12, 0};
      for (int i = 0; i < 20; i++)
         vecs[7 + i] = '{i, 0, (i < MAX_FILL) ? 12 : 0, 1};
      vecs[27] = '{31, 32, 31, 0};
      vecs[28] = '{3, 31, 31, 1};

      #12;
      resetDut();
      checkOutput("rst_in_ready", int'(in_ready), 1);

      // Table: fill before/after confident pixels, saturation, threshold edge.
      for (int i = 0; i < 29; i++) begin
         applyStimulus(vecs[i].disp, vecs[i].conf);
         checkBeat($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_filled);
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("drain_valid", int'(out_valid), 0);

      // Full row passes straight through, one beat per cycle.
      resetDut();
      for (int col = 0; col < FW; col++) begin
         applyStimulus(col % 32, 255);
         checkBeat("row_pass", col % 32, 0);
      end
      // Row ending in 20, next row starting with invalid pixels: no cross-row fill.
      for (int col = 0; col < FW; col++) begin
         applyStimulus(20, 255);
      end
      checkBeat("row_end", 20, 0);
      for (int col = 0; col < 3; col++) begin
         applyStimulus(17, 5);
         checkBeat("row_start_fill", 0, 1);
      end
      applyStimulus(4, 100);
      checkBeat("row_resume", 4, 0);
      applyStimulus(9, 0);
      checkBeat("row_fill_after", 4, 1);
      in_valid = 1'b0;
      drain();

      // Randomized full frame with back-pressure.
      resetDut();
      fd_count  = 0;
      pop_count = 0;
      ready_pct = 50;
      driveRandom(FW * FH, 12);
      drain();
      checkOutput("frame1_outputs", pop_count, FW * FH);
      checkOutput("frame1_done_count", fd_count, 1);

      // Partial frame aborted by reset at row 40, then a fresh frame.
      resetDut();
      fd_count  = 0;
      ready_pct = 100;
      driveRandom(40 * FW + 17, 0);
      checkOutput("pre_abort_valid", int'(out_valid), 1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("abort_valid", int'(out_valid), 0);
      checkOutput("abort_data", int'(out_data), 0);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      checkOutput("abort_done_count", fd_count, 0);
      pop_count = 0;
      ready_pct = 75;
      driveRandom(FW * FH, 8);
      drain();
      checkOutput("frame2_outputs", pop_count, FW * FH);
      checkOutput("frame2_done_count", fd_count, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      tests_failed++;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
